// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - packet FIFO feeding a runtime-divisor UART serializer
// Optional parity bit per frame when UART_TX_PARITY_EN is defined.
module uart_tx_buffered #(
    parameter int DIV_W         = 16,
    parameter int BITS_PER_WORD = 8,
    parameter int W_OUT         = 16,
    parameter int DEPTH         = 4,
    parameter int STOP_BITS     = 1,
    parameter int PARITY_ODD    = 0
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [DIV_W-1:0]             baud_div,
    input  logic                         s_valid,
    input  logic [W_OUT-1:0]             s_data,
    output logic                         s_ready,
    output logic                         tx,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

    localparam int NUM_WORDS = W_OUT / BITS_PER_WORD;
    localparam int CNT_W     = $clog2(DEPTH + 1);
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int WRD_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int BIT_W     = (BITS_PER_WORD > 2) ? $clog2(BITS_PER_WORD) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
`ifdef UART_TX_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [WRD_W-1:0]    word_q, word_d;
    logic [W_OUT-1:0]    sh_q, sh_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                rdy_q, rdy_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [PTR_W-1:0]    wr_q, wr_d;
    logic [PTR_W-1:0]    rd_q, rd_d;
`ifdef UART_TX_PARITY_EN
    logic                par_q, par_d;
`endif

    logic [W_OUT-1:0]    mem_q [DEPTH];

    logic                push;
    logic                load;
    logic                bit_end;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        bit_d   = bit_q;
        word_d  = word_q;
        sh_d    = sh_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        load    = 1'b0;
        push    = s_valid && rdy_q;
        bit_end = (cnt_q == div_q - DIV_W'(1));

        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + DIV_W'(1);
        end else begin
            cnt_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    load = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                    par_d   = 1'b0;
`endif
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    // The packet shifts right one bit per data slot, so the next word lands at bit 0.
                    sh_d = sh_q >> 1;
`ifdef UART_TX_PARITY_EN
                    par_d = par_q ^ sh_q[0];
`endif
                    if (bit_q == BIT_W'(BITS_PER_WORD - 1)) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                        bit_d = '0;
                        if (word_q == WRD_W'(NUM_WORDS - 1)) begin
                            if (count_q != '0) begin
                                load = 1'b1;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end else begin
                            word_d  = word_q + WRD_W'(1);
                            state_d = S_START;
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The divisor is captured only here, so it stays fixed for the whole packet.
        if (load) begin
            sh_d    = mem_q[rd_q];
            div_d   = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
            cnt_d   = '0;
            bit_d   = '0;
            word_d  = '0;
            state_d = S_START;
            rd_d    = (rd_q == PTR_W'(DEPTH - 1)) ? '0 : rd_q + PTR_W'(1);
        end

        if (push) begin
            wr_d = (wr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_q + PTR_W'(1);
        end

        case ({push, load})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        rdy_d = (count_d < CNT_W'(DEPTH));

        case (state_q)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = sh_q[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = par_q ^ (PARITY_ODD != 0);
`endif
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_q != S_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= DIV_W'(2);
            bit_q   <= '0;
            word_q  <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
            count_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            word_q  <= word_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
            count_q <= count_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= s_data;
        end
    end

    assign s_ready    = rdy_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - trace-level reference model bench for uart_tx_buffered
module tb_uart_tx_buffered;

    localparam int DEPTH      = 4;
    localparam int BPW        = 8;
    localparam int NW         = 2;
    localparam int STOP_BITS  = 1;
    localparam int PARITY_ODD = 0;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME = 1 + BPW + PAR + STOP_BITS;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] baud_div;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;
    logic        tx;
    logic        busy;
    logic [2:0]  fifo_count;

    always #5 clk = ~clk;

    uart_tx_buffered dut (
        .clk        (clk),
        .rstn       (rstn),
        .baud_div   (baud_div),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    int total = 0;
    int bad   = 0;
    int cyc;
    int pidx;

    logic        tx_log[$];
    logic        busy_log[$];
    logic        rdy_log[$];
    int          cnt_log[$];
    int          div_log[$];
    int          acc_edge[$];
    logic [15:0] acc_data[$];
    logic [15:0] pkts[$];
    int          ps[$];
    int          pe[$];
    int          pdiv[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic hs;
        @(negedge clk);
        tx_log.push_back(tx);
        busy_log.push_back(busy);
        rdy_log.push_back(s_ready);
        cnt_log.push_back(int'(fifo_count));
        div_log.push_back(int'(baud_div));
        hs = s_valid && s_ready;
        @(posedge clk);
        cyc++;
        if (hs) begin
            acc_edge.push_back(cyc);
            acc_data.push_back(s_data);
        end
        #1;
        if (hs) begin
            pidx++;
            if (pidx < pkts.size()) s_data = pkts[pidx];
            else s_valid = 1'b0;
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rstn    = 1'b0;
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset tx", tx, 1'b1);
        chk("reset busy", busy, 1'b0);
        chk("reset fifo_count", fifo_count, 0);
        chk("reset s_ready", s_ready, 1'b0);
        rstn = 1'b1;
        cyc  = 0;
        tx_log.delete(); busy_log.delete(); rdy_log.delete();
        cnt_log.delete(); div_log.delete();
        acc_edge.delete(); acc_data.delete(); pkts.delete();
        ps.delete(); pe.delete(); pdiv.delete();
    endtask

    task automatic start_pkts();
        pidx = 0;
        if (pkts.size() > 0) begin
            s_data  = pkts[0];
            s_valid = 1'b1;
        end
    endtask

    // Expected line level at a given clock offset inside a packet.
    function automatic logic exp_bit(input logic [15:0] d, input int v, input int off);
        int slot, w, pos;
        logic [15:0] sh;
        logic [7:0]  wd;
        slot = off / v;
        w    = slot / FRAME;
        pos  = slot % FRAME;
        sh   = d >> (w * BPW);
        wd   = sh[7:0];
        if (pos == 0) return 1'b0;
        if (pos <= BPW) return wd[pos-1];
        if (PAR == 1 && pos == BPW + 1) return (^wd) ^ (PARITY_ODD != 0);
        return 1'b1;
    endfunction

    function automatic logic [7:0] decode(input int s, input int v, input int w, input int first_bit);
        logic [7:0] d;
        int idx;
        for (int b = 0; b < 8; b++) begin
            idx = s + (w * FRAME + first_bit + b) * v + v / 2;
            d[b] = (idx < tx_log.size()) ? tx_log[idx] : 1'bx;
        end
        return d;
    endfunction

    // Packets start 2 clocks after acceptance, or right when the previous one ends if still queued.
    task automatic check_trace(input string tag);
        int L, eprev, s, v, e, i, f_tx, f_bs, f_ct, f_rd, nacc, npop;
        logic etx, ebs, erd;
        int ect;
        logic etx_a[$], ebs_a[$], erd_a[$];
        int ect_a[$];
        L = tx_log.size();
        eprev = 0;
        ps.delete(); pe.delete(); pdiv.delete();
        for (int k = 0; k < acc_edge.size(); k++) begin
            s = (acc_edge[k] + 2 > eprev) ? acc_edge[k] + 2 : eprev;
            if (s - 2 >= L) break;
            v = div_log[s-2];
            if (v < 2) v = 2;
            e = s + NW * FRAME * v;
            ps.push_back(s); pe.push_back(e); pdiv.push_back(v);
            eprev = e;
        end
        f_tx = -1; f_bs = -1; f_ct = -1; f_rd = -1;
        for (i = 0; i < L; i++) begin
            etx = 1'b1; ebs = 1'b0; nacc = 0; npop = 0;
            for (int k = 0; k < ps.size(); k++) begin
                if (i >= ps[k] && i < pe[k]) begin
                    etx = exp_bit(acc_data[k], pdiv[k], i - ps[k]);
                    ebs = 1'b1;
                end
                if (ps[k] - 1 <= i) npop++;
            end
            for (int k = 0; k < acc_edge.size(); k++) if (acc_edge[k] <= i) nacc++;
            ect = nacc - npop;
            erd = (i == 0) ? 1'b0 : (ect < DEPTH);
            etx_a.push_back(etx); ebs_a.push_back(ebs); ect_a.push_back(ect); erd_a.push_back(erd);
            if (f_tx < 0 && tx_log[i] !== etx) f_tx = i;
            if (f_bs < 0 && busy_log[i] !== ebs) f_bs = i;
            if (f_ct < 0 && cnt_log[i] != ect) f_ct = i;
            if (f_rd < 0 && rdy_log[i] !== erd) f_rd = i;
        end
        if (f_tx < 0) f_tx = L - 1;
        if (f_bs < 0) f_bs = L - 1;
        if (f_ct < 0) f_ct = L - 1;
        if (f_rd < 0) f_rd = L - 1;
        chk($sformatf("%s tx@%0d", tag, f_tx), tx_log[f_tx], etx_a[f_tx]);
        chk($sformatf("%s busy@%0d", tag, f_bs), busy_log[f_bs], ebs_a[f_bs]);
        chk($sformatf("%s fifo_count@%0d", tag, f_ct), cnt_log[f_ct], ect_a[f_ct]);
        chk($sformatf("%s s_ready@%0d", tag, f_rd), rdy_log[f_rd], erd_a[f_rd]);
    endtask

    function automatic int count_ones(input int which);
        int n = 0;
        for (int i = 0; i < tx_log.size(); i++) begin
            if (which == 0 && busy_log[i] === 1'b1) n++;
            if (which == 1 && tx_log[i] === 1'b0) n++;
        end
        return n;
    endfunction

    function automatic int busy_span();
        int f = -1, l = -1;
        for (int i = 0; i < busy_log.size(); i++) begin
            if (busy_log[i] === 1'b1) begin
                if (f < 0) f = i;
                l = i;
            end
        end
        return (f < 0) ? 0 : l - f + 1;
    endfunction

    initial begin
        int first_low, rise, mx;
        logic [15:0] got;
        rstn = 1'b0; baud_div = 16'd4; s_valid = 1'b0; s_data = '0;

        // Single packet, reset release behaviour
        do_reset();
        baud_div = 16'd4;
        pkts.push_back(16'hA53C);
        start_pkts();
        run(120);
        chk("s_ready before first edge", rdy_log[0], 1'b0);
        chk("s_ready one cycle after release", rdy_log[1], 1'b1);
        chk("idle tx after release", tx_log[0], 1'b1);
        chk("single accepts", acc_edge.size(), 1);
        check_trace("single");
        first_low = -1;
        for (int i = 0; i < tx_log.size(); i++) if (first_low < 0 && tx_log[i] === 1'b0) first_low = i;
        chk("single start latency", first_low - acc_edge[0], 2);
        chk("single word0", decode(first_low, 4, 0, 1), 8'h3C);
        chk("single word1", decode(first_low, 4, 1, 1), 8'hA5);
        chk("single stop bit", tx_log[first_low + (2 * FRAME - 1) * 4 + 2], 1'b1);
        chk("single busy clocks", count_ones(0), NW * FRAME * 4);

        // Backpressure with six random packets
        do_reset();
        baud_div = 16'd4;
        for (int k = 0; k < 6; k++) pkts.push_back(16'($urandom));
        start_pkts();
        run(560);
        check_trace("backpressure");
        chk("bp accepts", acc_edge.size(), 6);
        for (int k = 1; k < 5; k++) chk($sformatf("bp accept edge %0d", k), acc_edge[k] - acc_edge[0], k);
        chk("bp full count", cnt_log[acc_edge[4]], 4);
        chk("bp full s_ready", rdy_log[acc_edge[4]], 1'b0);
        rise = -1;
        for (int i = acc_edge[4]; i < rdy_log.size(); i++) if (rise < 0 && rdy_log[i] === 1'b1) rise = i;
        chk("bp s_ready rise", rise - acc_edge[0], 81);
        chk("bp accept edge 5", acc_edge[5] - acc_edge[0], 82);
        mx = 0;
        foreach (cnt_log[i]) if (cnt_log[i] > mx) mx = cnt_log[i];
        chk("bp max fifo_count", mx, DEPTH);
        chk("bp busy span", busy_span(), 6 * NW * FRAME * 4);
        chk("bp busy contiguous", count_ones(0), busy_span());
        for (int k = 0; k < ps.size(); k++) begin
            got = {decode(ps[k], pdiv[k], 1, 1), decode(ps[k], pdiv[k], 0, 1)};
            chk($sformatf("bp packet %0d data", k), got, pkts[k]);
        end

        // Divisor change in the middle of packet 0
        do_reset();
        baud_div = 16'd4;
        for (int k = 0; k < 2; k++) pkts.push_back(16'($urandom));
        start_pkts();
        run(55);
        baud_div = 16'd8;
        run(300);
        check_trace("divchange");
        chk("div busy span", busy_span(), NW * FRAME * 4 + NW * FRAME * 8);
        chk("div busy contiguous", count_ones(0), busy_span());
        if (ps.size() == 2) begin
            chk("div pkt0 rate", pdiv[0], 4);
            chk("div pkt1 data", {decode(ps[1], 8, 1, 1), decode(ps[1], 8, 0, 1)}, pkts[1]);
        end else begin
            chk("div packets modelled", ps.size(), 2);
        end

        // Divisor below the minimum is treated as 2
        do_reset();
        baud_div = 16'd1;
        pkts.push_back(16'($urandom));
        start_pkts();
        run(80);
        check_trace("clamp");
        chk("clamp busy clocks", count_ones(0), NW * FRAME * 2);

`ifdef UART_TX_PARITY_EN
        do_reset();
        baud_div = 16'd4;
        pkts.push_back(16'h0703);
        start_pkts();
        run(120);
        check_trace("parity");
        chk("parity busy clocks", count_ones(0), 88);
        if (ps.size() == 1) begin
            chk("parity bit word0", tx_log[ps[0] + (BPW + 1) * 4 + 2], 1'b0);
            chk("parity bit word1", tx_log[ps[0] + (FRAME + BPW + 1) * 4 + 2], 1'b1);
        end else begin
            chk("parity packets modelled", ps.size(), 1);
        end
`endif

        // Reset during data bit 3 of word 0 with two packets queued
        do_reset();
        baud_div = 16'd4;
        for (int k = 0; k < 3; k++) pkts.push_back(16'($urandom));
        start_pkts();
        run(21);
        chk("midreset queued count", fifo_count, 2);
        got = pkts[0];
        chk("midreset data bit 3", tx, got[3]);
        #2;
        rstn = 1'b0;
        #1;
        chk("midreset tx immediate", tx, 1'b1);
        chk("midreset fifo_count immediate", fifo_count, 0);
        chk("midreset busy immediate", busy, 1'b0);
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        tx_log.delete(); busy_log.delete(); rdy_log.delete(); cnt_log.delete(); div_log.delete();
        run(150);
        chk("post-reset tx low samples", count_ones(1), 0);
        chk("post-reset busy samples", count_ones(0), 0);
        mx = 0;
        foreach (cnt_log[i]) if (cnt_log[i] > mx) mx = cnt_log[i];
        chk("post-reset fifo_count", mx, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
